// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the fetch handshake and the datapath control strobes that connect
// the instruction sequencer to the rest of the core.
//
//   slave  modport : the sequencer itself
//   master modport : the fetch unit / datapath side that drives it
//
// Signals (direction seen from the sequencer):
//   Op_code    in  32         instruction word, type in Op_code[27:24]
//   ins_valid  in  1          fetch unit presents Op_code
//   ins_ready  out 1          sequencer accepts Op_code this cycle
//   cond_true  in  1          condition-unit result
//   mem_req    out 1          RAM request, held until acknowledged
//   mem_we     out 1          RAM write qualifier
//   mem_ack    in  1          RAM completion
//   falu_start out 1          FALU start pulse
//   falu_done  in  1          FALU completion
//   reg_we     out 1          register-file write pulse
//   pc_inc     out 1          PC +1 pulse
//   pc_load    out 1          PC load pulse
//   sp_inc     out 1          stack pointer +1 pulse
//   sp_dec     out 1          stack pointer -1 pulse
//   halted     out 1          core stopped
//   fault      out 1          illegal opcode or memory timeout
//   retired    out CNT_WIDTH  count of completed instructions
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          Op_code;
    logic                 ins_valid;
    logic                 ins_ready;
    logic                 cond_true;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_ack;
    logic                 falu_start;
    logic                 falu_done;
    logic                 reg_we;
    logic                 pc_inc;
    logic                 pc_load;
    logic                 sp_inc;
    logic                 sp_dec;
    logic                 halted;
    logic                 fault;
    logic [CNT_WIDTH-1:0] retired;

    modport slave (
        input  Op_code, ins_valid, cond_true, mem_ack, falu_done,
        output ins_ready, mem_req, mem_we, falu_start, reg_we, pc_inc,
               pc_load, sp_inc, sp_dec, halted, fault, retired
    );

    modport master (
        output Op_code, ins_valid, cond_true, mem_ack, falu_done,
        input  ins_ready, mem_req, mem_we, falu_start, reg_we, pc_inc,
               pc_load, sp_inc, sp_dec, halted, fault, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control sequencer. Accepts one instruction per handshake,
// latches its type field and then steps the ALU / FALU / condition / jump /
// RAM / stack datapaths through the per-cycle enables on the bus.
//
// Ports:
//   clk  in  single clock, all state on the rising edge
//   rst  in  synchronous active-high reset
//   bus  instr_sequencer_if.slave (fetch handshake + datapath strobes)
//
// Parameters:
//   MEM_TIMEOUT  cycles mem_req may stay unacknowledged before a fault (1..255)
//   CNT_WIDTH    width of the retired-instruction counter
//
// Build option:
//   INSTR_SEQ_FALU_EN  when defined, FALU instructions start the FALU and
//                      wait for falu_done; otherwise FALU is an illegal type.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
`ifdef INSTR_SEQ_FALU_EN
        S_FWAIT = 3'd3,
`endif
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [3:0] T_ALU   = 4'd0;
    localparam logic [3:0] T_FALU  = 4'd1;
    localparam logic [3:0] T_COND  = 4'd2;
    localparam logic [3:0] T_JUMP  = 4'd3;
    localparam logic [3:0] T_SAVE  = 4'd4;
    localparam logic [3:0] T_LOAD  = 4'd5;
    localparam logic [3:0] T_HALT  = 4'd6;
    localparam logic [3:0] T_PUSH  = 4'd7;
    localparam logic [3:0] T_POP   = 4'd8;
    localparam logic [3:0] T_CALL  = 4'd9;
    localparam logic [3:0] T_RET   = 4'd10;

    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    state_t               r_state;
    logic [3:0]           r_type;
    logic [7:0]           r_timeout;
    logic [CNT_WIDTH-1:0] r_retired;

    state_t     w_nextState;
    logic       w_insReady;
    logic       w_memReq;
    logic       w_memWe;
    logic       w_regWe;
    logic       w_pcInc;
    logic       w_pcLoad;
    logic       w_spInc;
    logic       w_spDec;
    logic       w_halted;
    logic       w_fault;
    logic       w_complete;
    logic       w_timeoutHit;
    logic [8:0] w_reqCount;
    logic       w_unused;
`ifdef INSTR_SEQ_FALU_EN
    logic       w_faluStart;
`endif

    // r_timeout holds how many request cycles have already gone by without
    // an ack. The EXEC cycle counts as the first one because mem_req is
    // already on the bus there, so mem_req is high MEM_TIMEOUT cycles in
    // total before the sequencer gives up.
    assign w_reqCount   = {1'b0, r_timeout} + 9'd1;
    assign w_timeoutHit = (w_reqCount >= TIMEOUT_LIM);

    // Output and next-state decode. Everything comes from the state, the
    // latched type and the live completion/condition inputs, never from the
    // raw Op_code.
    always_comb begin
        w_nextState = r_state;
        w_insReady  = 1'b0;
        w_memReq    = 1'b0;
        w_memWe     = 1'b0;
        w_regWe     = 1'b0;
        w_pcInc     = 1'b0;
        w_pcLoad    = 1'b0;
        w_spInc     = 1'b0;
        w_spDec     = 1'b0;
        w_halted    = 1'b0;
        w_fault     = 1'b0;
        w_complete  = 1'b0;
`ifdef INSTR_SEQ_FALU_EN
        w_faluStart = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_insReady = 1'b1;
                if (bus.ins_valid) begin
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_type)
                    T_ALU: begin
                        w_regWe     = 1'b1;
                        w_pcInc     = 1'b1;
                        w_complete  = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    T_COND: begin
                        w_pcLoad    = bus.cond_true;
                        w_pcInc     = ~bus.cond_true;
                        w_complete  = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    T_JUMP: begin
                        w_pcLoad    = 1'b1;
                        w_complete  = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    T_SAVE, T_PUSH, T_CALL: begin
                        w_memReq    = 1'b1;
                        w_memWe     = 1'b1;
                        w_nextState = S_MEM;
                    end
                    T_LOAD: begin
                        w_memReq    = 1'b1;
                        w_nextState = S_MEM;
                    end
                    // The stack pointer is pre-decremented so the read
                    // address is already correct for the request.
                    T_POP, T_RET: begin
                        w_spDec     = 1'b1;
                        w_memReq    = 1'b1;
                        w_nextState = S_MEM;
                    end
                    T_HALT: begin
                        w_nextState = S_HALT;
                    end
`ifdef INSTR_SEQ_FALU_EN
                    T_FALU: begin
                        w_faluStart = 1'b1;
                        w_nextState = S_FWAIT;
                    end
`else
                    T_FALU: begin
                        w_nextState = S_FAULT;
                    end
`endif
                    default: begin
                        w_nextState = S_FAULT;
                    end
                endcase
            end
            S_MEM: begin
                w_memReq = 1'b1;
                w_memWe  = (r_type == T_SAVE) || (r_type == T_PUSH) ||
                           (r_type == T_CALL);
                // An ack arriving together with the timeout limit still
                // completes the access.
                if (bus.mem_ack) begin
                    w_complete  = 1'b1;
                    w_nextState = S_FETCH;
                    case (r_type)
                        T_SAVE: begin
                            w_pcInc = 1'b1;
                        end
                        T_LOAD, T_POP: begin
                            w_regWe = 1'b1;
                            w_pcInc = 1'b1;
                        end
                        T_PUSH: begin
                            w_spInc = 1'b1;
                            w_pcInc = 1'b1;
                        end
                        T_CALL: begin
                            w_spInc  = 1'b1;
                            w_pcLoad = 1'b1;
                        end
                        T_RET: begin
                            w_pcLoad = 1'b1;
                        end
                        default: begin
                            w_pcInc = 1'b0;
                        end
                    endcase
                end else if (w_timeoutHit) begin
                    w_nextState = S_FAULT;
                end
            end
`ifdef INSTR_SEQ_FALU_EN
            S_FWAIT: begin
                if (bus.falu_done) begin
                    w_regWe     = 1'b1;
                    w_pcInc     = 1'b1;
                    w_complete  = 1'b1;
                    w_nextState = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                w_halted = 1'b1;
            end
            S_FAULT: begin
                w_halted = 1'b1;
                w_fault  = 1'b1;
            end
            default: begin
                w_nextState = S_FAULT;
            end
        endcase
    end

    // State, latched type, memory timeout counter and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_type    <= 4'd0;
            r_timeout <= 8'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_FETCH && bus.ins_valid) begin
                r_type <= bus.Op_code[27:24];
            end
            if (r_state == S_EXEC) begin
                r_timeout <= 8'd1;
            end else if (r_state == S_MEM && !bus.mem_ack) begin
                r_timeout <= r_timeout + 8'd1;
            end
            if (w_complete) begin
                r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // While reset is held every output is forced low, since the state
    // register only becomes defined on the first reset edge.
    assign bus.ins_ready = w_insReady & ~rst;
    assign bus.mem_req   = w_memReq   & ~rst;
    assign bus.mem_we    = w_memWe    & ~rst;
    assign bus.reg_we    = w_regWe    & ~rst;
    assign bus.pc_inc    = w_pcInc    & ~rst;
    assign bus.pc_load   = w_pcLoad   & ~rst;
    assign bus.sp_inc    = w_spInc    & ~rst;
    assign bus.sp_dec    = w_spDec    & ~rst;
    assign bus.halted    = w_halted   & ~rst;
    assign bus.fault     = w_fault    & ~rst;
    assign bus.retired   = rst ? '0 : r_retired;

`ifdef INSTR_SEQ_FALU_EN
    assign bus.falu_start = w_faluStart & ~rst;
    assign w_unused       = ^{bus.Op_code[31:28], bus.Op_code[23:0]};
`else
    assign bus.falu_start = 1'b0;
    assign w_unused       = ^{bus.Op_code[31:28], bus.Op_code[23:0], bus.falu_done};
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer. Each issued instruction pushes its
// expected completion strobes {reg_we, pc_inc, pc_load, sp_inc} onto a
// scoreboard queue; a negedge monitor pops and compares whenever the DUT
// shows completion strobes. Cycle counts, handshake and status outputs are
// compared directly from the stimulus tasks.
// Honors INSTR_SEQ_FALU_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_WIDTH   = 16;

    logic clk;
    logic rst;

    instr_sequencer_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    instr_sequencer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int testsRun;
    int testsFailed;
    int tbRetired;
    logic [3:0] sbQueue[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Completion monitor: any completion strobe must match the next
    // scoreboard entry, and PC / SP strobes must never collide.
    always @(negedge clk) begin
        logic [3:0] obs;
        logic [3:0] exp;
        if (!rst) begin
            obs = {bus.reg_we, bus.pc_inc, bus.pc_load, bus.sp_inc};
            if (obs != 4'd0) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'(obs), 32'd0);
                end else begin
                    exp = sbQueue.pop_front();
                    checkOutput("pulses", 32'(obs), 32'(exp));
                end
            end
            if (bus.pc_inc && bus.pc_load)
                checkOutput("pc_exclusive", 32'd1, 32'd0);
            if (bus.sp_inc && bus.sp_dec)
                checkOutput("sp_exclusive", 32'd1, 32'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1;
        bus.ins_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.falu_done = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_outputs",
                    32'({bus.ins_ready, bus.mem_req, bus.mem_we, bus.falu_start,
                         bus.reg_we, bus.pc_inc, bus.pc_load, bus.sp_inc,
                         bus.sp_dec, bus.halted, bus.fault}), 32'd0);
        checkOutput("rst_retired", 32'(bus.retired), 32'd0);
        tick();
        rst = 1'b0;
        sbQueue.delete();
        tbRetired = 0;
        tick();
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(bus.ins_ready), 32'd1);
        checkOutput("post_rst_status", 32'({bus.halted, bus.fault}), 32'd0);
        checkOutput("post_rst_retired", 32'(bus.retired), 32'd0);
        tick();
    endtask

    // Present one instruction for a single accept cycle, then put an illegal
    // word on Op_code so any use of the unlatched word would show up.
    task automatic acceptOnly(input logic [31:0] op, input string tag);
        bus.Op_code   = op;
        bus.ins_valid = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_accept_ready"}, 32'(bus.ins_ready), 32'd1);
        tick();
        bus.ins_valid = 1'b0;
        bus.Op_code   = 32'h0F00_0000;
    endtask

    // Issue one instruction that completes normally and check its timing.
    task automatic applyStimulus(input logic [31:0] op, input logic condTrue,
                                 input logic isMem, input int ackDelay,
                                 input logic [3:0] expPulses, input logic expWe,
                                 input logic expSpDec, input string tag);
        int reqCycles;
        int weBad;
        bus.cond_true = condTrue;
        sbQueue.push_back(expPulses);
        acceptOnly(op, tag);
        if (!isMem) begin
            @(negedge clk);
            checkOutput({tag, "_exec_memreq"}, 32'(bus.mem_req), 32'd0);
            tick();
        end else begin
            reqCycles = 0;
            weBad     = 0;
            for (int c = 0; c < 40; c++) begin
                bus.mem_ack = (c == ackDelay);
                @(negedge clk);
                if (bus.mem_req) begin
                    reqCycles++;
                    if (bus.mem_we !== expWe) weBad++;
                end
                if (c == 0)
                    checkOutput({tag, "_exec_spdec"}, 32'(bus.sp_dec), 32'(expSpDec));
                tick();
                if (c == ackDelay) break;
            end
            bus.mem_ack = 1'b0;
            checkOutput({tag, "_memreq_cycles"}, 32'(reqCycles), 32'(ackDelay + 1));
            checkOutput({tag, "_mem_we"}, 32'(weBad), 32'd0);
        end
        tbRetired++;
        @(negedge clk);
        checkOutput({tag, "_ready_again"}, 32'(bus.ins_ready), 32'd1);
        checkOutput({tag, "_retired"}, 32'(bus.retired), 32'(tbRetired));
        tick();
    endtask

    task automatic runTimeout;
        int reqCycles;
        acceptOnly(32'h0500_0000, "timeout");
        reqCycles = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.mem_req) reqCycles++;
            tick();
        end
        @(negedge clk);
        checkOutput("timeout_req_cycles", 32'(reqCycles), 32'(MEM_TIMEOUT));
        checkOutput("timeout_fault", 32'({bus.fault, bus.halted}), 32'b11);
        checkOutput("timeout_retired", 32'(bus.retired), 32'(tbRetired));
        tick();
    endtask

    task automatic runHalt;
        int bad;
        acceptOnly(32'h0600_0000, "halt");
        tick();
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.halted !== 1'b1 || bus.ins_ready !== 1'b0 || bus.fault !== 1'b0 ||
                bus.mem_req !== 1'b0)
                bad++;
            tick();
        end
        checkOutput("halt_hold", 32'(bad), 32'd0);
        checkOutput("halt_retired", 32'(bus.retired), 32'(tbRetired));
    endtask

    task automatic runFalu;
`ifdef INSTR_SEQ_FALU_EN
        int bad;
        sbQueue.push_back(4'b1100);
        acceptOnly(32'h0100_0000, "falu");
        @(negedge clk);
        checkOutput("falu_start", 32'(bus.falu_start), 32'd1);
        tick();
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.falu_start !== 1'b0 || bus.ins_ready !== 1'b0) bad++;
            tick();
        end
        checkOutput("falu_wait", 32'(bad), 32'd0);
        bus.falu_done = 1'b1;
        @(negedge clk);
        tick();
        bus.falu_done = 1'b0;
        tbRetired++;
        @(negedge clk);
        checkOutput("falu_ready_again", 32'(bus.ins_ready), 32'd1);
        checkOutput("falu_retired", 32'(bus.retired), 32'(tbRetired));
        tick();
`else
        acceptOnly(32'h0100_0000, "falu");
        tick();
        @(negedge clk);
        checkOutput("falu_fault", 32'({bus.fault, bus.halted}), 32'b11);
        checkOutput("falu_start_tied", 32'(bus.falu_start), 32'd0);
        tick();
        doReset();
`endif
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        tbRetired     = 0;
        rst           = 1'b1;
        bus.Op_code   = 32'h0;
        bus.ins_valid = 1'b0;
        bus.cond_true = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.falu_done = 1'b0;

        doReset();

        //            opcode        cond  mem   ack  pulses   we    spdec tag
        applyStimulus(32'h0000_0000, 1'b0, 1'b0, 0, 4'b1100, 1'b0, 1'b0, "alu");
        applyStimulus(32'h0200_0000, 1'b1, 1'b0, 0, 4'b0010, 1'b0, 1'b0, "cond_t");
        applyStimulus(32'h0200_0000, 1'b0, 1'b0, 0, 4'b0100, 1'b0, 1'b0, "cond_f");
        applyStimulus(32'h0312_3456, 1'b0, 1'b0, 0, 4'b0010, 1'b0, 1'b0, "jump");
        applyStimulus(32'h0700_0000, 1'b0, 1'b1, 3, 4'b0101, 1'b1, 1'b0, "push");
        applyStimulus(32'h0400_0000, 1'b0, 1'b1, 1, 4'b0100, 1'b1, 1'b0, "save");
        applyStimulus(32'h0500_0000, 1'b0, 1'b1, 2, 4'b1100, 1'b0, 1'b0, "load");
        applyStimulus(32'h0800_0000, 1'b0, 1'b1, 1, 4'b1100, 1'b0, 1'b1, "pop");
        applyStimulus(32'h0900_0000, 1'b0, 1'b1, 2, 4'b0011, 1'b1, 1'b0, "call");
        applyStimulus(32'h0A00_0000, 1'b0, 1'b1, 1, 4'b0010, 1'b0, 1'b1, "ret");
        // Ack exactly when the timeout limit is reached still completes.
        applyStimulus(32'h0500_0000, 1'b0, 1'b1, MEM_TIMEOUT - 1, 4'b1100, 1'b0, 1'b0,
                      "load_edge");

        runFalu();

        acceptOnly(32'h0B00_0000, "illegal");
        tick();
        @(negedge clk);
        checkOutput("illegal_fault", 32'({bus.fault, bus.halted, bus.ins_ready}), 32'b110);
        tick();
        doReset();

        applyStimulus(32'h0000_0000, 1'b0, 1'b0, 0, 4'b1100, 1'b0, 1'b0, "alu2");
        runTimeout();
        doReset();

        runHalt();
        doReset();
        applyStimulus(32'h0000_0000, 1'b0, 1'b0, 0, 4'b1100, 1'b0, 1'b0, "alu3");

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
